pc060ha_mailbox: RTL



---
 rtl/pc060ha_pkg.sv | 9 +
 rtl/pc060ha_mbox_dir.sv | 65 ++++++
 rtl/pc060ha_mailbox.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pc060ha_pkg.sv
// Shared widths and special index codes for the PC060HA-style nibble mailbox.
package pc060ha_pkg;
    localparam int NIB_W = 4;
    localparam int PTR_W = 3;

    localparam logic [PTR_W-1:0] IDX_STATUS  = 3'd4;
    localparam logic [PTR_W-1:0] IDX_NMI_OFF = 3'd5;
    localparam logic [PTR_W-1:0] IDX_NMI_ON  = 3'd6;
endpackage

// File: rtl/pc060ha_mbox_dir.sv
// One mailbox direction: 4 nibbles, sender writes, receiver reads, flag A/B mirrors.
// Read data is the pre-edge value, so a same-cycle write is invisible to the reader.
module pc060ha_mbox_dir
    import pc060ha_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [1:0]       wr_idx_i,
    input  logic [NIB_W-1:0] wr_dat_i,
    input  logic             rd_en_i,
    input  logic [1:0]       rd_idx_i,
    output logic [NIB_W-1:0] rd_dat_o,
    output logic             flag_a_o,
    output logic             flag_b_o,
    output logic [1:0]       flag_nxt_o,
    output logic             set_a_o,
    output logic             set_b_o,
    output logic             clr_a_o,
    output logic             clr_b_o
);
    logic [NIB_W-1:0] nib_q [4];
    logic flag_a_q, flag_b_q, flag_a_d, flag_b_d;
    logic set_a_q, set_b_q, clr_a_q, clr_b_q;
    logic set_a_d, set_b_d, clr_a_d, clr_b_d;

    always_comb begin
        set_a_d  = wr_en_i && (wr_idx_i == 2'd1);
        set_b_d  = wr_en_i && (wr_idx_i == 2'd3);
        clr_a_d  = rd_en_i && (rd_idx_i == 2'd1);
        clr_b_d  = rd_en_i && (rd_idx_i == 2'd3);
        // set wins over a same-cycle clear
        flag_a_d = set_a_d | (flag_a_q & ~clr_a_d);
        flag_b_d = set_b_d | (flag_b_q & ~clr_b_d);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 4; i++) nib_q[i] <= '0;
            flag_a_q <= 1'b0;
            flag_b_q <= 1'b0;
            set_a_q  <= 1'b0;
            set_b_q  <= 1'b0;
            clr_a_q  <= 1'b0;
            clr_b_q  <= 1'b0;
        end else begin
            if (wr_en_i) nib_q[wr_idx_i] <= wr_dat_i;
            flag_a_q <= flag_a_d;
            flag_b_q <= flag_b_d;
            set_a_q  <= set_a_d;
            set_b_q  <= set_b_d;
            clr_a_q  <= clr_a_d;
            clr_b_q  <= clr_b_d;
        end
    end

    assign rd_dat_o   = nib_q[rd_idx_i];
    assign flag_a_o   = flag_a_q;
    assign flag_b_o   = flag_b_q;
    assign flag_nxt_o = {flag_b_d, flag_a_d};
    assign set_a_o    = set_a_q;
    assign set_b_o    = set_b_q;
    assign clr_a_o    = clr_a_q;
    assign clr_b_o    = clr_b_q;
endmodule

// File: rtl/pc060ha_mailbox.sv
// Two-port nibble mailbox: per-side auto-indexed pointers, status/NMI/reset indices.
// All outputs registered; reads and writes complete on the sampling edge, never stall.
module pc060ha_mailbox
    import pc060ha_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             M_WE,
    input  logic             M_RE,
    input  logic             M_A0,
    input  logic [NIB_W-1:0] M_DI,
    output logic [NIB_W-1:0] M_DO,
    input  logic             S_WE,
    input  logic             S_RE,
    input  logic             S_A0,
    input  logic [NIB_W-1:0] S_DI,
    output logic [NIB_W-1:0] S_DO,
    output logic             S_NMI,
    output logic             S_RSTOUT,
    output logic             M2S_SET_A,
    output logic             M2S_SET_B,
    output logic             M2S_CLR_A,
    output logic             M2S_CLR_B,
    output logic             S2M_SET_A,
    output logic             S2M_SET_B,
    output logic             S2M_CLR_A,
    output logic             S2M_CLR_B
);
    logic [PTR_W-1:0] m_ptr_q, m_ptr_d, s_ptr_q, s_ptr_d;
    logic [NIB_W-1:0] m_do_q, m_do_d, s_do_q, s_do_d;
    logic nmi_en_q, nmi_en_d, s_nmi_q, s_nmi_d, rstout_q, rstout_d;
    logic m_wr_nib, m_rd_nib, s_wr_nib, s_rd_nib;
    logic [NIB_W-1:0] m2s_rd_dat, s2m_rd_dat;
    logic m2s_a, m2s_b, s2m_a, s2m_b;
    logic [1:0] m2s_nxt, s2m_nxt_unused;

    // Pointers 0..3 address nibbles; 4..7 are special indices
    assign m_wr_nib = M_WE && M_A0 && !m_ptr_q[2];
    assign m_rd_nib = M_RE && M_A0 && !m_ptr_q[2];
    assign s_wr_nib = S_WE && S_A0 && !s_ptr_q[2];
    assign s_rd_nib = S_RE && S_A0 && !s_ptr_q[2];

    pc060ha_mbox_dir u_m2s (
        .clk_i(CLK), .rst_i(RESET),
        .wr_en_i(m_wr_nib), .wr_idx_i(m_ptr_q[1:0]), .wr_dat_i(M_DI),
        .rd_en_i(s_rd_nib), .rd_idx_i(s_ptr_q[1:0]), .rd_dat_o(m2s_rd_dat),
        .flag_a_o(m2s_a), .flag_b_o(m2s_b), .flag_nxt_o(m2s_nxt),
        .set_a_o(M2S_SET_A), .set_b_o(M2S_SET_B),
        .clr_a_o(M2S_CLR_A), .clr_b_o(M2S_CLR_B)
    );

    pc060ha_mbox_dir u_s2m (
        .clk_i(CLK), .rst_i(RESET),
        .wr_en_i(s_wr_nib), .wr_idx_i(s_ptr_q[1:0]), .wr_dat_i(S_DI),
        .rd_en_i(m_rd_nib), .rd_idx_i(m_ptr_q[1:0]), .rd_dat_o(s2m_rd_dat),
        .flag_a_o(s2m_a), .flag_b_o(s2m_b), .flag_nxt_o(s2m_nxt_unused),
        .set_a_o(S2M_SET_A), .set_b_o(S2M_SET_B),
        .clr_a_o(S2M_CLR_A), .clr_b_o(S2M_CLR_B)
    );

    always_comb begin
        m_ptr_d  = m_ptr_q;
        m_do_d   = m_do_q;
        rstout_d = rstout_q;
        if (M_WE && !M_A0) begin
            m_ptr_d = M_DI[PTR_W-1:0];
        end else if (m_wr_nib || m_rd_nib) begin
            m_ptr_d = {1'b0, m_ptr_q[1:0] + 2'd1};
        end
        if (M_WE && M_A0 && (m_ptr_q == IDX_STATUS)) rstout_d = M_DI[0];
        if (M_RE) begin
            if (!M_A0)                     m_do_d = {1'b0, m_ptr_q};
            else if (!m_ptr_q[2])          m_do_d = s2m_rd_dat;
            else if (m_ptr_q == IDX_STATUS) m_do_d = {m2s_b, m2s_a, s2m_b, s2m_a};
            else                           m_do_d = '0;
        end
    end

    always_comb begin
        s_ptr_d  = s_ptr_q;
        s_do_d   = s_do_q;
        nmi_en_d = nmi_en_q;
        if (S_WE && !S_A0) begin
            s_ptr_d = S_DI[PTR_W-1:0];
        end else if (s_wr_nib || s_rd_nib) begin
            s_ptr_d = {1'b0, s_ptr_q[1:0] + 2'd1};
        end
        if (S_WE && S_A0 && (s_ptr_q == IDX_NMI_OFF)) nmi_en_d = 1'b0;
        if (S_WE && S_A0 && (s_ptr_q == IDX_NMI_ON))  nmi_en_d = 1'b1;
        if (S_RE) begin
            if (!S_A0)                     s_do_d = {1'b0, s_ptr_q};
            else if (!s_ptr_q[2])          s_do_d = m2s_rd_dat;
            else if (s_ptr_q == IDX_STATUS) s_do_d = {s2m_b, s2m_a, m2s_b, m2s_a};
            else                           s_do_d = '0;
        end
        // next-state flags so NMI lands in the same cycle as the SET pulse
        s_nmi_d = nmi_en_d & (|m2s_nxt);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            m_ptr_q  <= '0;
            s_ptr_q  <= '0;
            m_do_q   <= '0;
            s_do_q   <= '0;
            nmi_en_q <= 1'b0;
            s_nmi_q  <= 1'b0;
            rstout_q <= 1'b0;
        end else begin
            m_ptr_q  <= m_ptr_d;
            s_ptr_q  <= s_ptr_d;
            m_do_q   <= m_do_d;
            s_do_q   <= s_do_d;
            nmi_en_q <= nmi_en_d;
            s_nmi_q  <= s_nmi_d;
            rstout_q <= rstout_d;
        end
    end

    assign M_DO     = m_do_q;
    assign S_DO     = s_do_q;
    assign S_NMI    = s_nmi_q;
    assign S_RSTOUT = rstout_q;
endmodule
